// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate: key codes, PIN width and the
// pin_entry state encoding.
package parking_pkg;

    localparam int         PIN_W         = 7;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;

    typedef enum logic [2:0] {
        PE_IDLE      = 3'b001,
        PE_ONE_DIGIT = 3'b010,
        PE_FULL      = 3'b100
    } pe_state_t;

    function automatic logic [1:0] pe_digit_cnt(input pe_state_t s);
        case (s)
            PE_ONE_DIGIT: pe_digit_cnt = 2'd1;
            PE_FULL:      pe_digit_cnt = 2'd2;
            default:      pe_digit_cnt = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Inactivity timer for pin_entry: counts cycles while run is high, pulses
// expired on the edge the count reaches TIMEOUT_CYCLES, then saturates.
module entry_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic expired
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (restart || !run) begin
            r_count <= '0;
        end else if (r_count != CNT_SAT) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // High during the cycle whose closing edge brings the count to the limit.
    assign expired = run && (r_count == CNT_LAST);

endmodule

// File: rtl/pin_entry.sv
// Keypad front-end: gathers two decimal digits, submits them as a binary PIN
// on ENTER, and aborts partial entries on CLEAR, timeout or loss of enable.
module pin_entry
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [PIN_W-1:0] pin,
    output logic             pin_valid,
    output logic             entry_err,
    output logic [1:0]       digit_cnt
);

    pe_state_t        r_state;
    pe_state_t        w_state_nxt;
    logic [PIN_W-1:0] r_acc;
    logic [PIN_W-1:0] w_acc_nxt;
    logic [PIN_W-1:0] w_acc_x10;
    logic [PIN_W-1:0] w_key_val;
    logic             w_is_digit;
    logic             w_is_clear;
    logic             w_is_enter;
    logic             w_restart;
    logic             w_run;
    logic             w_expired;
    logic             w_pin_load;
    logic             w_err;

    assign w_is_digit = key_valid && (key_code <= KEY_MAX_DIGIT);
    assign w_is_clear = key_valid && (key_code == KEY_CLEAR);
    assign w_is_enter = key_valid && (key_code == KEY_ENTER);
    assign w_key_val  = PIN_W'(key_code);
    assign w_acc_x10  = (r_acc << 3) + (r_acc << 1);
    assign w_run      = enable && (r_state != PE_IDLE);

    entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .restart(w_restart),
        .run    (w_run),
        .expired(w_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= PE_IDLE;
            r_acc     <= '0;
            pin       <= '0;
            pin_valid <= 1'b0;
            entry_err <= 1'b0;
            digit_cnt <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            pin_valid <= w_pin_load;
            entry_err <= w_err;
            digit_cnt <= pe_digit_cnt(w_state_nxt);
            if (w_pin_load) begin
                pin <= r_acc;
            end
        end
    end

    // Keys take priority over a coinciding timer expiry; a digit in FULL is
    // not an accepted key, so it neither restarts the timer nor masks expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_restart   = 1'b0;
        w_pin_load  = 1'b0;
        w_err       = 1'b0;

        if (!enable) begin
            w_state_nxt = PE_IDLE;
            w_acc_nxt   = '0;
        end else begin
            case (r_state)
                PE_IDLE: begin
                    if (w_is_digit) begin
                        w_acc_nxt   = w_key_val;
                        w_state_nxt = PE_ONE_DIGIT;
                        w_restart   = 1'b1;
                    end
                end
                PE_ONE_DIGIT: begin
                    if (w_is_digit) begin
                        w_acc_nxt   = w_acc_x10 + w_key_val;
                        w_state_nxt = PE_FULL;
                        w_restart   = 1'b1;
                    end else if (w_is_enter) begin
                        w_err       = 1'b1;
                        w_acc_nxt   = '0;
                        w_state_nxt = PE_IDLE;
                    end else if (w_is_clear) begin
                        w_restart   = 1'b1;
                        w_acc_nxt   = '0;
                        w_state_nxt = PE_IDLE;
                    end else if (w_expired) begin
                        w_err       = 1'b1;
                        w_acc_nxt   = '0;
                        w_state_nxt = PE_IDLE;
                    end
                end
                PE_FULL: begin
                    if (w_is_enter) begin
                        w_pin_load  = 1'b1;
                        w_acc_nxt   = '0;
                        w_state_nxt = PE_IDLE;
                    end else if (w_is_clear) begin
                        w_restart   = 1'b1;
                        w_acc_nxt   = '0;
                        w_state_nxt = PE_IDLE;
                    end else if (w_expired) begin
                        w_err       = 1'b1;
                        w_acc_nxt   = '0;
                        w_state_nxt = PE_IDLE;
                    end
                end
                default: begin
                    w_acc_nxt   = '0;
                    w_state_nxt = PE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_entry.sv
// Bench for pin_entry: directed scenarios plus random key streams, checked
// against a digit-list reference model.
module tb_pin_entry;

    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       key_valid;
    logic [3:0] key_code;
    logic [6:0] pin;
    logic       pin_valid;
    logic       entry_err;
    logic [1:0] digit_cnt;

    always #5 clock = ~clock;

    pin_entry #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .key_valid(key_valid),
        .key_code (key_code),
        .pin      (pin),
        .pin_valid(pin_valid),
        .entry_err(entry_err),
        .digit_cnt(digit_cnt)
    );

    int n_checks = 0;
    int n_errs   = 0;

    int m_digits[$];
    int m_idle = 0;
    int m_pin  = 0;
    int m_pv   = 0;
    int m_err  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: an entry is just the list of digits typed so far plus the
    // number of edges since the last accepted key.
    task automatic model_edge(input bit en, input bit kv, input logic [3:0] kc);
        bit accepted;
        accepted = 0;
        m_pv  = 0;
        m_err = 0;
        if (!en) begin
            m_digits.delete();
            m_idle = 0;
            return;
        end
        if (kv && kc <= 4'd9) begin
            if (m_digits.size() < 2) begin
                m_digits.push_back(int'(kc));
                accepted = 1;
            end
        end else if (kv && kc == 4'hA) begin
            if (m_digits.size() > 0) accepted = 1;
            m_digits.delete();
        end else if (kv && kc == 4'hB) begin
            if (m_digits.size() == 2) begin
                m_pin = m_digits[0] * 10 + m_digits[1];
                m_pv  = 1;
            end else if (m_digits.size() == 1) begin
                m_err = 1;
            end
            if (m_digits.size() > 0) accepted = 1;
            m_digits.delete();
        end
        if (accepted || m_digits.size() == 0) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == T) begin
                m_err = 1;
                m_digits.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic step(input bit en, input bit kv, input logic [3:0] kc);
        enable    = en;
        key_valid = kv;
        key_code  = kc;
        @(posedge clock);
        model_edge(en, kv, kc);
        @(negedge clock);
        chk("pin", int'(pin), m_pin);
        chk("pin_valid", int'(pin_valid), m_pv);
        chk("entry_err", int'(entry_err), m_err);
        chk("digit_cnt", int'(digit_cnt), m_digits.size());
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, 1'b1, kc);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 4'h0);
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(negedge clock);
        chk("rst_pin", int'(pin), 0);
        chk("rst_pv", int'(pin_valid), 0);
        chk("rst_err", int'(entry_err), 0);
        chk("rst_cnt", int'(digit_cnt), 0);
        reset = 1'b1;
        @(negedge clock);

        key(4'd7); chk("cnt_after_7", int'(digit_cnt), 1);
        key(4'd2); chk("cnt_after_72", int'(digit_cnt), 2);
        key(4'hB);
        chk("pv_72", int'(pin_valid), 1);
        chk("pin_72", int'(pin), 72);
        chk("cnt_after_enter", int'(digit_cnt), 0);
        idle();
        chk("pv_one_cycle", int'(pin_valid), 0);

        key(4'd9); key(4'd9); key(4'd5);
        chk("cnt_third_ignored", int'(digit_cnt), 2);
        key(4'hB);
        chk("pin_99", int'(pin), 99);

        key(4'd4); key(4'hB);
        chk("short_err", int'(entry_err), 1);
        chk("short_no_pv", int'(pin_valid), 0);
        chk("short_pin_kept", int'(pin), 99);
        key(4'd1); key(4'hA); key(4'd3); key(4'd0); key(4'hB);
        chk("pin_30", int'(pin), 30);

        key(4'd5);
        repeat (T - 1) idle();
        chk("to_not_yet", int'(entry_err), 0);
        idle();
        chk("to_err", int'(entry_err), 1);
        chk("to_idle", int'(digit_cnt), 0);

        key(4'd5);
        repeat (T - 1) idle();
        key(4'd6);
        chk("to_key_wins_err", int'(entry_err), 0);
        chk("to_key_wins_cnt", int'(digit_cnt), 2);
        key(4'hA);

        key(4'd7); key(4'd2);
        step(1'b0, 1'b0, 4'h0);
        chk("en_low_cnt", int'(digit_cnt), 0);
        key(4'hB);
        chk("en_abort_no_pv", int'(pin_valid), 0);
        chk("en_abort_no_err", int'(entry_err), 0);
        key(4'd7); key(4'd2);
        step(1'b0, 1'b1, 4'hB);
        chk("en_fall_enter_pv", int'(pin_valid), 0);
        chk("en_fall_pin", int'(pin), 30);

        key(4'd3);
        for (int c = 12; c <= 15; c++) key(4'(c));
        chk("ignored_codes_cnt", int'(digit_cnt), 1);
        key(4'hA);

        key(4'd3); key(4'd1); key(4'hB);
        chk("pin_31", int'(pin), 31);
        key(4'd8);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pin", int'(pin), 0);
        chk("async_rst_cnt", int'(digit_cnt), 0);
        m_pin = 0;
        m_digits.delete();
        m_idle = 0;
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bit         en;
            bit         kv;
            int         r;
            logic [3:0] kc;
            en = ($urandom_range(0, 19) != 0);
            kv = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 9);
            if (r < 6)       kc = 4'($urandom_range(0, 9));
            else if (r == 6) kc = 4'hA;
            else if (r < 9)  kc = 4'hB;
            else             kc = 4'($urandom_range(12, 15));
            step(en, kv, kc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
